// File: rtl/rename_retire_queue_pkg.sv
// rename_retire_queue_pkg: widths shared between the rename file and its retire queue.
package rename_retire_queue_pkg;
  localparam int NAME_WIDTH = 1;
  localparam int DEPTH = 4;
  localparam int PTR_WIDTH = 2;
  typedef logic [NAME_WIDTH-1:0] name_t;
  typedef logic [PTR_WIDTH:0] count_t;
endpackage

// File: rtl/rename_retire_match.sv
// rename_retire_match: writeback CAM producing the per-slot done-set vector.
module rename_retire_match
  import rename_retire_queue_pkg::*;
#(
  parameter int name_width = NAME_WIDTH,
  parameter int depth = DEPTH
) (
  input  logic [depth-1:0][name_width-1:0] names,
  input  logic [depth-1:0]                 valid,
  input  logic [name_width-1:0]            wb_name_1,
  input  logic                             wb_e_1,
  input  logic [name_width-1:0]            wb_name_2,
  input  logic                             wb_e_2,
  output logic [depth-1:0]                 done_set
);
  for (genvar i = 0; i < depth; i++) begin : g_slot
    assign done_set[i] = valid[i] && ((wb_e_1 && names[i] == wb_name_1) ||
                                      (wb_e_2 && names[i] == wb_name_2));
  end
endmodule

// File: rtl/rename_retire_queue.sv
// rename_retire_queue: in-order retirement tracker driving the rename file's name-free port.
module rename_retire_queue
  import rename_retire_queue_pkg::*;
#(
  parameter int name_width = NAME_WIDTH,
  parameter int depth = DEPTH,
  parameter int ptr_width = PTR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [name_width-1:0] ENQ_NAME,
  input  logic                  ENQ_E,
  output logic                  ENQ_READY,
  input  logic [name_width-1:0] WB_NAME_1,
  input  logic                  WB_E_1,
  input  logic [name_width-1:0] WB_NAME_2,
  input  logic                  WB_E_2,
  input  logic                  COMMIT_EN,
  input  logic                  FLUSH,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [ptr_width:0]    COUNT
);
  localparam logic [ptr_width:0] full_cnt = (ptr_width+1)'(depth);
  logic [depth-1:0][name_width-1:0] names;
  logic [depth-1:0] valid, done, valid_n, done_n, done_set;
  logic [ptr_width-1:0] head, tail;
  logic do_enq, retire;
  rename_retire_match #(.name_width(name_width), .depth(depth)) u_match (
    .names(names), .valid(valid),
    .wb_name_1(WB_NAME_1), .wb_e_1(WB_E_1),
    .wb_name_2(WB_NAME_2), .wb_e_2(WB_E_2),
    .done_set(done_set)
  );
  assign ENQ_READY = COUNT != full_cnt;
  assign do_enq = ENQ_E && ENQ_READY;
  assign retire = valid[head] && done[head] && COMMIT_EN && !FLUSH;
  // The enqueue overrides last so a same-cycle writeback never marks the new entry.
  always_comb begin
    valid_n = valid;
    done_n = done | done_set;
    if (retire) begin
      valid_n[head] = 1'b0;
      done_n[head] = 1'b0;
    end
    if (do_enq) begin
      valid_n[tail] = 1'b1;
      done_n[tail] = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      names <= '0;
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      COUNT <= '0;
      FE <= 1'b0;
      NAME_F <= '0;
    end else if (FLUSH) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      COUNT <= '0;
      FE <= 1'b0;
    end else begin
      valid <= valid_n;
      done <= done_n;
      if (do_enq) names[tail] <= ENQ_NAME;
      tail <= tail + ptr_width'(do_enq);
      head <= head + ptr_width'(retire);
      COUNT <= COUNT + (ptr_width+1)'(do_enq) - (ptr_width+1)'(retire);
      FE <= retire;
      if (retire) NAME_F <= names[head];
    end
  end
endmodule

// File: tb/tb_rename_retire_queue.sv
// tb_rename_retire_queue: directed vectors with hand-computed expectations.
module tb_rename_retire_queue;
  logic       CLK = 0, RST = 0;
  logic [3:0] ENQ_NAME = 0, WB_NAME_1 = 0, WB_NAME_2 = 0;
  logic       ENQ_E = 0, WB_E_1 = 0, WB_E_2 = 0, COMMIT_EN = 1, FLUSH = 0;
  logic       ENQ_READY, FE;
  logic [3:0] NAME_F;
  logic [2:0] COUNT;
  int n_checks = 0, n_errors = 0;

  rename_retire_queue #(.name_width(4), .depth(4), .ptr_width(2)) dut (
    .CLK(CLK), .RST(RST), .ENQ_NAME(ENQ_NAME), .ENQ_E(ENQ_E), .ENQ_READY(ENQ_READY),
    .WB_NAME_1(WB_NAME_1), .WB_E_1(WB_E_1), .WB_NAME_2(WB_NAME_2), .WB_E_2(WB_E_2),
    .COMMIT_EN(COMMIT_EN), .FLUSH(FLUSH), .NAME_F(NAME_F), .FE(FE), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic [3:0] n);
    ENQ_NAME = n;
    ENQ_E = 1;
    tick();
    ENQ_E = 0;
  endtask

  task automatic wb(input logic e1, input logic [3:0] n1, input logic e2, input logic [3:0] n2);
    WB_E_1 = e1;
    WB_NAME_1 = n1;
    WB_E_2 = e2;
    WB_NAME_2 = n2;
    tick();
    WB_E_1 = 0;
    WB_E_2 = 0;
  endtask

  task automatic flush;
    FLUSH = 1;
    tick();
    FLUSH = 0;
  endtask

  task automatic fe_is(input string tag, input logic e, input logic [3:0] n);
    check({tag, "_fe"}, FE, e);
    if (e) check({tag, "_name"}, NAME_F, n);
  endtask

  initial begin
    #12 RST = 1;
    tick();
    check("rst_count", COUNT, 0);
    check("rst_ready", ENQ_READY, 1);
    check("rst_fe", FE, 0);
    check("rst_namef", NAME_F, 0);
    // single retirement latency
    enq(4); enq(5); enq(6);
    check("t1_count3", COUNT, 3);
    wb(1, 4, 0, 0);
    fe_is("t1_wb_edge", 0, 0);
    tick();
    fe_is("t1_retire", 1, 4);
    check("t1_count2", COUNT, 2);
    tick();
    fe_is("t1_no56", 0, 0);
    flush();
    check("t1_flush_count", COUNT, 0);
    // out-of-order completion
    enq(4); enq(5); enq(6);
    wb(1, 6, 0, 0);
    fe_is("t2_after6", 0, 0);
    wb(1, 5, 0, 0);
    fe_is("t2_after5", 0, 0);
    tick();
    fe_is("t2_wait", 0, 0);
    wb(1, 4, 0, 0);
    fe_is("t2_wb4", 0, 0);
    tick(); fe_is("t2_r4", 1, 4);
    tick(); fe_is("t2_r5", 1, 5);
    tick(); fe_is("t2_r6", 1, 6);
    tick(); fe_is("t2_idle", 0, 0);
    check("t2_count", COUNT, 0);
    // full and wrap
    flush();
    enq(4); enq(5); enq(6); enq(7);
    check("t3_full_ready", ENQ_READY, 0);
    check("t3_full_count", COUNT, 4);
    enq(3);
    check("t3_ignored_count", COUNT, 4);
    wb(1, 4, 0, 0);
    ENQ_NAME = 3;
    ENQ_E = 1;
    tick();
    fe_is("t3_r4", 1, 4);
    check("t3_count3", COUNT, 3);
    check("t3_ready_back", ENQ_READY, 1);
    tick();
    ENQ_E = 0;
    check("t3_count4", COUNT, 4);
    check("t3_ready_full", ENQ_READY, 0);
    wb(1, 5, 1, 6);
    fe_is("t3_dual", 0, 0);
    wb(1, 7, 1, 3);
    fe_is("t3_r5", 1, 5);
    tick(); fe_is("t3_r6", 1, 6);
    tick(); fe_is("t3_r7", 1, 7);
    tick(); fe_is("t3_r3_slot0", 1, 3);
    check("t3_count0", COUNT, 0);
    tick(); fe_is("t3_idle", 0, 0);
    // dual writeback and unknown name
    enq(4); enq(5);
    wb(1, 2, 0, 0);
    tick();
    fe_is("t4_unknown", 0, 0);
    check("t4_unknown_count", COUNT, 2);
    wb(1, 5, 1, 4);
    fe_is("t4_wb_edge", 0, 0);
    tick(); fe_is("t4_r4", 1, 4);
    tick(); fe_is("t4_r5", 1, 5);
    check("t4_count", COUNT, 0);
    // commit gating
    enq(4);
    COMMIT_EN = 0;
    wb(1, 4, 0, 0);
    tick(); tick();
    fe_is("t5_gated", 0, 0);
    check("t5_gated_count", COUNT, 1);
    COMMIT_EN = 1;
    tick();
    fe_is("t5_release", 1, 4);
    check("t5_count", COUNT, 0);
    // flush wins over enqueue and retirement
    enq(4); enq(5); enq(6);
    wb(1, 4, 1, 5);
    FLUSH = 1;
    ENQ_NAME = 7;
    ENQ_E = 1;
    tick();
    FLUSH = 0;
    ENQ_E = 0;
    check("t6_count", COUNT, 0);
    check("t6_ready", ENQ_READY, 1);
    fe_is("t6_fe", 0, 0);
    tick(); tick();
    fe_is("t6_fe_after", 0, 0);
    check("t6_count_after", COUNT, 0);
    // asynchronous reset drops a pending free
    enq(4); enq(5);
    wb(1, 4, 0, 0);
    tick();
    fe_is("t7_pre", 1, 4);
    #2 RST = 0;
    #1;
    check("t7_async_fe", FE, 0);
    check("t7_async_count", COUNT, 0);
    check("t7_async_namef", NAME_F, 0);
    check("t7_async_ready", ENQ_READY, 1);
    tick();
    RST = 1;
    tick();
    fe_is("t7_post", 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rename_retire_queue.md
Name: rename_retire_queue

Overview:
- In-order retirement tracker for the rename register file; it drives the rename file's name-free port (NAME_F/FE).
- Each rename allocation is enqueued in program order. Data writebacks mark their entries complete by matching the physical name.
- Completed entries retire from the head in order. Each retirement issues a registered one-cycle free request carrying the retired entry's name.

Parameters:
- name_width, 1: physical name width; must match the rename file.
- depth, 4: queue entries; power of two, at least 2.
- ptr_width, 2: log2(depth).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- ENQ_NAME  in  name_width  newly allocated physical name (the rename file's NAME_OUT).
- ENQ_E  in  1  enqueue strobe; legal only when ENQ_READY is 1.
- ENQ_READY  out  1  queue not full.
- WB_NAME_1  in  name_width  writeback port 1 name (paired with the rename file's NAME_IN_1).
- WB_E_1  in  1  writeback port 1 valid.
- WB_NAME_2  in  name_width  writeback port 2 name.
- WB_E_2  in  1  writeback port 2 valid.
- COMMIT_EN  in  1  retirement permitted this cycle.
- FLUSH  in  1  discard all entries.
- NAME_F  out  name_width  name being freed (registered).
- FE  out  1  free strobe (registered, one cycle per retirement).
- COUNT  out  ptr_width+1  live entry count.

Behaviour:
- State per slot: name, valid, done. head_ptr and tail_ptr are ptr_width bits wide and wrap modulo depth. The counter is ptr_width+1 bits wide.
- Reset (RST=0, asynchronous): all valid=0, done=0, head=tail=0, count=0. Outputs: FE=0, NAME_F=0, ENQ_READY=1, COUNT=0.
- ENQ_READY = (count != depth). It is based on count only: a retirement in the same cycle does not free a slot for an enqueue in that cycle.
- Enqueue: when ENQ_E && ENQ_READY, slot[tail] gets name=ENQ_NAME, valid=1, done=0, and tail advances. ENQ_E while full is ignored.
- Writeback:
  - For each port k with WB_E_k=1, every slot with valid && name==WB_NAME_k gets done=1.
  - Names of live entries are unique, so at most one slot matches.
  - A name with no match is ignored; a writeback to an already-done slot has no effect.
  - Both ports may hit different slots in the same cycle.
  - A writeback matching a name being enqueued in the same cycle does not mark the new entry.
- Retire condition: slot[head].valid && slot[head].done && COMMIT_EN && !FLUSH, evaluated on registered state.
  - A done bit set at edge t is first usable for retirement in the cycle after t.
  - On retire: the slot is invalidated, head advances, and FE<=1, NAME_F<=slot[head].name at that edge.
  - Otherwise FE<=0 and NAME_F holds its value.
  - At most one retirement per cycle.
- Latency: WB_E in cycle c → retire decision in cycle c+1 (entry at head) → FE=1 in cycle c+2.
- Count update: count_next = count + enq − retire. Simultaneous enqueue and retire leaves count unchanged. Count wraps never.
- Empty queue: no retirement; FE stays 0.
- Full queue: ENQ_READY=0. A retirement in that cycle raises ENQ_READY in the following cycle.
- FLUSH (synchronous): all valid/done cleared, head=tail=0, count=0, FE<=0.
  - No frees are issued for flushed entries.
  - FLUSH wins over enqueue, writeback and retirement in the same cycle.
- Reset mid-operation: immediate return to reset state regardless of CLK; a pending FE is dropped.
- No combinational path exists from any input to FE or NAME_F.

Decomposition:
- Shared package: rename name typedef (name_width) and the queue pointer/count widths. These are shared with the rename file so widths stay consistent.
- One sub-module is natural: rename_retire_match. It is a combinational CAM that compares WB_NAME_1/2 against all valid slot names and produces a depth-bit done-set vector.
- Pointers, count and retire/FE logic stay in the top module.

Test Plan:
- Reset, then enqueue names 4, 5, 6 and writeback 4 → FE=1 with NAME_F=4 exactly two cycles after the WB; COUNT goes 3 → 2; no FE for 5 or 6.
- Out-of-order completion: enqueue 4, 5, 6; writeback 6 then 5 → no FE until 4 completes. Then writeback 4 → FE pulses with NAME_F 4, 5, 6 on three consecutive cycles.
- Full and wrap (depth=4): enqueue 4, 5, 6, 7 → ENQ_READY=0 and ENQ_E of 3 is ignored. Retire 4 → ENQ_READY=1 next cycle; enqueue 3 lands in slot 0; COUNT=4.
- Dual writeback: both ports hit names 5 and 4 in the same cycle with 4 at head → consecutive FE for 4 then 5. A writeback of unknown name 2 has no effect.
- COMMIT_EN=0 with head done → no FE and COUNT holds. Raising COMMIT_EN → FE the next cycle.
- FLUSH with 3 entries, 2 done, and a simultaneous ENQ_E → COUNT=0, ENQ_READY=1, FE=0 thereafter. Asserting RST low mid-stream clears FE/COUNT without waiting for a clock edge.
